banked_mem_array: RTL and testbench
===================================

BANKED_MEM_ARRAY -- requirements
Module: banked_mem_array

Interface
REQ-001 SHALL have parameter NBANKS, default 4, meaning the number of memory banks (range 2..16).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning words per bank (power of two).
REQ-003 SHALL have parameter DW, default 32, meaning the data width in bits (multiple of 8).
REQ-004 SHALL have derived localparam AW = log2(DEPTH) and NBE = DW/8.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-007 SHALL have port wr_en, input, 1 bit: write request.
REQ-008 SHALL have port wr_sel, input, NBANKS bits: one-hot write bank select.
REQ-009 SHALL have port w_addr, input, AW bits: write word address within the bank.
REQ-010 SHALL have port w_data, input, DW bits: write data.
REQ-011 SHALL have port w_be, input, NBE bits: byte enables; bit k covers w_data[8k+7:8k].
REQ-012 SHALL have port rd_en, input, 1 bit: read request.
REQ-013 SHALL have port rd_sel, input, NBANKS bits: one-hot read bank select.
REQ-014 SHALL have port r_addr, input, AW bits: read word address within the bank.
REQ-015 SHALL have port r_data, output, DW bits: registered read data.
REQ-016 SHALL have port r_valid, output, 1 bit: one-cycle pulse qualifying r_data.
REQ-017 SHALL have port sel_err, output, 1 bit: sticky select-error flag.
REQ-018 SHALL have port err_cnt, output, 8 bits: saturating count of rejected requests.
REQ-019 SHALL have port err_clr, input, 1 bit: clears sel_err and err_cnt.

Function
REQ-020 A select SHALL be valid only when exactly one bit is set; all-zero and multi-hot selects are invalid.
REQ-021 When wr_en=1 and wr_sel is valid, the selected bank SHALL write w_data at w_addr on the next edge, only in the bytes with w_be=1.
REQ-022 When rd_en=1 and rd_sel is valid, r_data SHALL show the selected bank's word at r_addr one cycle later, with r_valid=1 for exactly that cycle.
REQ-023 Unselected banks SHALL see neither write enable nor address activity.
REQ-024 r_data SHALL hold its last value when no valid read completes; r_valid SHALL be 0 in that case.
REQ-025 A read and a write to the same bank and address in the same cycle SHALL be write-first: enabled bytes come from w_data and the other bytes from the old contents.
REQ-026 Simultaneous read and write to different banks, or to different addresses, SHALL both complete independently.
REQ-027 An invalid select with its enable high SHALL drop the request: no write, and no r_valid for a read.
REQ-028 Each dropped request SHALL set sel_err and increment err_cnt by 1; a write and a read both dropped in one cycle SHALL add 2.
REQ-029 err_cnt SHALL saturate at 255 and never wrap.
REQ-030 When err_clr and a new error occur in the same cycle, the error SHALL win: sel_err=1, and err_cnt equals the new increment (1 or 2).
REQ-031 A select with its enable low SHALL be ignored and SHALL NOT raise an error.

Reset
REQ-032 While rst=1: r_data=0, r_valid=0, sel_err=0, err_cnt=0, asynchronously.
REQ-033 A read issued in the cycle rst asserts SHALL be cancelled, with no r_valid after reset release.
REQ-034 Memory contents SHALL NOT be reset and are undefined until written.
REQ-035 The first request SHALL be accepted on the first rising edge with rst=0.

Verification
REQ-036 Write 0xDEADBEEF, w_be=1111, bank 2, addr 5; then read bank 2, addr 5 -> r_data=0xDEADBEEF, r_valid=1 exactly one cycle later.
REQ-037 Bank 0, addr 3 holds 0x11223344; write 0xAABBCCDD with w_be=0101 and read the same address in the same cycle -> r_data=0x11BB33DD next cycle.
REQ-038 wr_en=1 with wr_sel=0110 -> no bank changes, sel_err=1, err_cnt=1; next cycle err_clr=1 alone -> sel_err=0, err_cnt=0.
REQ-039 Issue 300 invalid reads -> err_cnt=255 and stays 255; err_clr together with one invalid write -> err_cnt=1, sel_err=1.
REQ-040 Issue a read on bank 1 and assert rst between edges -> r_valid=0 and r_data=0 immediately; no r_valid after release.
REQ-041 Sweep NBANKS=2, 4, 8 and DEPTH=16: write unique values to every bank and address, read all back -> every word matches, no cross-bank aliasing.

Source files
------------

// File: rtl/banked_mem_array.sv
// Banked byte-enable memory with one-hot bank selects and a one-cycle registered read.
// Reads bypass a same-cycle write (write-first). Dropped requests set a sticky flag and bump a saturating counter.

module banked_mem_bank #(
   parameter  int DEPTH = 1024,
   parameter  int DW    = 32,
   localparam int AW    = $clog2(DEPTH),
   localparam int NBE   = DW / 8
) (
   input  logic           clk,
   input  logic           we,
   input  logic [AW-1:0]  w_addr,
   input  logic [DW-1:0]  w_data,
   input  logic [NBE-1:0] w_be,
   input  logic           re,
   input  logic [AW-1:0]  r_addr,
   output logic [DW-1:0]  r_word
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < NBE; k++) begin
            if (w_be[k]) mem[w_addr][8*k +: 8] <= w_data[8*k +: 8];
         end
      end
   end

   // Idle banks return zero so the top can OR-combine all bank outputs.
   always_comb begin
      r_word = '0;
      if (re) begin
         r_word = mem[r_addr];
         if (we && (w_addr == r_addr)) begin
            for (int k = 0; k < NBE; k++) begin
               if (w_be[k]) r_word[8*k +: 8] = w_data[8*k +: 8];
            end
         end
      end
   end
endmodule

module banked_mem_array #(
   parameter  int NBANKS = 4,
   parameter  int DEPTH  = 1024,
   parameter  int DW     = 32,
   localparam int AW     = $clog2(DEPTH),
   localparam int NBE    = DW / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [NBANKS-1:0] wr_sel,
   input  logic [AW-1:0]     w_addr,
   input  logic [DW-1:0]     w_data,
   input  logic [NBE-1:0]    w_be,
   input  logic              rd_en,
   input  logic [NBANKS-1:0] rd_sel,
   input  logic [AW-1:0]     r_addr,
   output logic [DW-1:0]     r_data,
   output logic              r_valid,
   output logic              sel_err,
   output logic [7:0]        err_cnt,
   input  logic              err_clr
);
   localparam int STAGES = 1;

   typedef struct packed {
      logic           en;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  data;
      logic [NBE-1:0] be;
   } wr_req_t;

   typedef struct packed {
      logic          en;
      logic [AW-1:0] addr;
   } rd_req_t;

   wr_req_t [NBANKS-1:0]         bank_wr;
   rd_req_t [NBANKS-1:0]         bank_rd;
   logic    [NBANKS-1:0][DW-1:0] bank_q;
   logic    [DW-1:0]             rd_word;
   logic    [STAGES:0]           vld_pipe;

   logic wr_ok, rd_ok, wr_drop, rd_drop;
   logic [1:0] err_inc;
   logic [8:0] err_sum;

   assign wr_ok   = wr_en &  $onehot(wr_sel);
   assign rd_ok   = rd_en &  $onehot(rd_sel);
   assign wr_drop = wr_en & ~$onehot(wr_sel);
   assign rd_drop = rd_en & ~$onehot(rd_sel);

   // Only the selected bank sees enable, address and data; all others are held at zero.
   always_comb begin
      for (int b = 0; b < NBANKS; b++) begin
         bank_wr[b] = '0;
         bank_rd[b] = '0;
         if (wr_ok && wr_sel[b]) begin
            bank_wr[b].en   = 1'b1;
            bank_wr[b].addr = w_addr;
            bank_wr[b].data = w_data;
            bank_wr[b].be   = w_be;
         end
         if (rd_ok && rd_sel[b]) begin
            bank_rd[b].en   = 1'b1;
            bank_rd[b].addr = r_addr;
         end
      end
   end

   for (genvar g = 0; g < NBANKS; g++) begin : g_bank
      banked_mem_bank #(.DEPTH(DEPTH), .DW(DW)) u_bank (
         .clk    (clk),
         .we     (bank_wr[g].en),
         .w_addr (bank_wr[g].addr),
         .w_data (bank_wr[g].data),
         .w_be   (bank_wr[g].be),
         .re     (bank_rd[g].en),
         .r_addr (bank_rd[g].addr),
         .r_word (bank_q[g])
      );
   end

   always_comb begin
      rd_word = '0;
      for (int b = 0; b < NBANKS; b++) rd_word = rd_word | bank_q[b];
   end

   assign vld_pipe[0] = rd_ok;
   assign r_valid     = vld_pipe[STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe[STAGES:1] <= '0;
         r_data             <= '0;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         if (rd_ok) r_data <= rd_word;
      end
   end

   assign err_inc = {1'b0, wr_drop} + {1'b0, rd_drop};
   assign err_sum = {1'b0, err_cnt} + {7'b0, err_inc};

   // A clear in the same cycle as a new drop restarts the count from that drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err <= 1'b0;
         err_cnt <= '0;
      end else if (err_clr) begin
         sel_err <= |err_inc;
         err_cnt <= {6'b0, err_inc};
      end else if (|err_inc) begin
         sel_err <= 1'b1;
         err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
      end
   end
endmodule

// File: tb/tb_banked_mem_array.sv
// Scoreboard bench for banked_mem_array: directed cases on a 4-bank instance plus
// full-fill sweeps on 2/4/8-bank instances.
module tb_banked_mem_array;
   localparam int NB = 4, DEP = 16, DW = 32, AW = 4, NBE = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, wr_en, rd_en, err_clr, r_valid, sel_err;
   logic [NB-1:0] wr_sel, rd_sel;
   logic [AW-1:0] w_addr, r_addr;
   logic [DW-1:0] w_data, r_data;
   logic [NBE-1:0] w_be;
   logic [7:0]    err_cnt;

   int n_chk = 0, n_pass = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   banked_mem_array #(.NBANKS(NB), .DEPTH(DEP), .DW(DW)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .w_addr(w_addr),
      .w_data(w_data), .w_be(w_be), .rd_en(rd_en), .rd_sel(rd_sel), .r_addr(r_addr),
      .r_data(r_data), .r_valid(r_valid), .sel_err(sel_err), .err_cnt(err_cnt),
      .err_clr(err_clr)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   typedef struct {
      logic [DW-1:0] d;
      int            c;
      string         tag;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] mdl [NB][DEP];
   logic [DW-1:0] last_rd = '0;

   always @(negedge clk) begin
      exp_t e;
      if (r_valid) begin
         if (sb.size() == 0) chk("rvalid_unexpected", 1, 0);
         else begin
            e = sb.pop_front();
            chk({e.tag, "_data"}, r_data, e.d);
            chk({e.tag, "_lat"}, cyc, e.c);
         end
      end
   end

   function automatic int idx(input logic [NB-1:0] s);
      for (int i = 0; i < NB; i++) if (s[i]) return i;
      return 0;
   endfunction

   task automatic apply(input logic we, input logic [NB-1:0] ws, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [NBE-1:0] wbe, input logic re,
                        input logic [NB-1:0] rs, input logic [AW-1:0] ra, input logic clr,
                        input string tag);
      exp_t e;
      logic [DW-1:0] rd;
      wr_en = we; wr_sel = ws; w_addr = wa; w_data = wd; w_be = wbe;
      rd_en = re; rd_sel = rs; r_addr = ra; err_clr = clr;
      if (re && $countones(rs) == 1) begin
         rd = mdl[idx(rs)][ra];
         if (we && ws == rs && wa == ra)
            for (int k = 0; k < NBE; k++) if (wbe[k]) rd[8*k +: 8] = wd[8*k +: 8];
         e.d = rd; e.c = cyc + 1; e.tag = tag;
         sb.push_back(e);
         last_rd = rd;
      end
      if (we && $countones(ws) == 1)
         for (int k = 0; k < NBE; k++) if (wbe[k]) mdl[idx(ws)][wa][8*k +: 8] = wd[8*k +: 8];
   endtask

   task automatic drive(input logic we, input logic [NB-1:0] ws, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [NBE-1:0] wbe, input logic re,
                        input logic [NB-1:0] rs, input logic [AW-1:0] ra, input logic clr,
                        input string tag);
      @(posedge clk); #1;
      apply(we, ws, wa, wd, wbe, re, rs, ra, clr, tag);
   endtask

   task automatic wr(input int b, input logic [AW-1:0] a, input logic [DW-1:0] d);
      drive(1, NB'(1) << b, a, d, '1, 0, '0, '0, 0, "wr");
   endtask

   task automatic rd(input int b, input logic [AW-1:0] a, input string tag);
      drive(0, '0, '0, '0, '0, 1, NB'(1) << b, a, 0, tag);
   endtask

   task automatic idle();
      drive(0, '0, '0, '0, '0, 0, '0, '0, 0, "idle");
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      chk(tag, sb.size(), 0);
   endtask

   // Independent instances that fill and read back every word.
   for (genvar gi = 0; gi < 3; gi++) begin : g_sw
      localparam int SB = 2 << gi;
      logic          s_rst, s_we, s_re, s_rv, s_err;
      logic [SB-1:0] s_ws, s_rs;
      logic [3:0]    s_wa, s_ra, s_be;
      logic [31:0]   s_wd, s_rdata;
      logic [7:0]    s_cnt;
      logic [31:0]   q[$];
      bit            done = 0;

      banked_mem_array #(.NBANKS(SB), .DEPTH(16), .DW(32)) u_sw (
         .clk(clk), .rst(s_rst), .wr_en(s_we), .wr_sel(s_ws), .w_addr(s_wa),
         .w_data(s_wd), .w_be(s_be), .rd_en(s_re), .rd_sel(s_rs), .r_addr(s_ra),
         .r_data(s_rdata), .r_valid(s_rv), .sel_err(s_err), .err_cnt(s_cnt),
         .err_clr(1'b0)
      );

      always @(negedge clk) begin
         if (s_rv) begin
            if (q.size() == 0) chk($sformatf("sweep%0d_unexpected", SB), 1, 0);
            else chk($sformatf("sweep%0d_data", SB), s_rdata, q.pop_front());
         end
      end

      initial begin
         s_rst = 1; s_we = 0; s_re = 0; s_ws = '0; s_rs = '0;
         s_wa = '0; s_ra = '0; s_wd = '0; s_be = '1;
         repeat (2) @(posedge clk);
         #1 s_rst = 0;
         for (int b = 0; b < SB; b++)
            for (int a = 0; a < 16; a++) begin
               @(posedge clk); #1;
               s_we = 1; s_ws = SB'(1) << b; s_wa = 4'(a);
               s_wd = 32'hA000_0000 | 32'(SB << 16) | 32'(b << 8) | 32'(a);
            end
         @(posedge clk); #1 s_we = 0;
         for (int b = 0; b < SB; b++)
            for (int a = 0; a < 16; a++) begin
               @(posedge clk); #1;
               s_re = 1; s_rs = SB'(1) << b; s_ra = 4'(a);
               q.push_back(32'hA000_0000 | 32'(SB << 16) | 32'(b << 8) | 32'(a));
            end
         @(posedge clk); #1 s_re = 0;
         repeat (3) @(posedge clk);
         chk($sformatf("sweep%0d_drain", SB), q.size(), 0);
         chk($sformatf("sweep%0d_errcnt", SB), s_cnt, 0);
         done = 1;
      end
   end

   initial begin
      int pulses;
      rst = 1;
      apply(0, '0, '0, '0, '0, 0, '0, '0, 0, "init");
      #12;
      chk("rst_rdata", r_data, 0);
      chk("rst_rvalid", r_valid, 0);
      chk("rst_selerr", sel_err, 0);
      chk("rst_errcnt", err_cnt, 0);
      @(posedge clk); #1 rst = 0;

      // basic write then read
      wr(2, 5, 32'hDEADBEEF);
      rd(2, 5, "req036");
      idle();
      @(negedge clk) chk("req036_const", r_data, 32'hDEADBEEF);

      // write-first with partial byte enables
      wr(0, 3, 32'h11223344);
      drive(1, 4'b0001, 3, 32'hAABBCCDD, 4'b0101, 1, 4'b0001, 3, 0, "req037_wf");
      idle();
      @(negedge clk) chk("req037_const", r_data, 32'h11BB33DD);
      rd(0, 3, "req037_post");

      // concurrent read/write to different bank / different address
      wr(1, 7, 32'h01234567);
      wr(1, 5, 32'h00000055);
      wr(3, 2, 32'h0F0F0F0F);
      drive(1, 4'b0010, 8, 32'h89ABCDEF, '1, 1, 4'b0100, 5, 0, "diff_bank");
      drive(1, 4'b0010, 9, 32'hCAFEF00D, '1, 1, 4'b0010, 7, 0, "diff_addr");
      drive(1, 4'b1000, 2, 32'hFFFFFFFF, 4'b0000, 1, 4'b1000, 2, 0, "be_none");
      rd(1, 8, "rd_b1a8");
      rd(1, 9, "rd_b1a9");
      idle();
      drain("drain_a");

      // multi-hot write dropped, then clear
      drive(1, 4'b0110, 5, 32'h0, '1, 0, '0, '0, 0, "bad_wr");
      idle();
      @(negedge clk);
      chk("badwr_selerr", sel_err, 1);
      chk("badwr_errcnt", err_cnt, 1);
      drive(0, '0, '0, '0, '0, 0, '0, '0, 1, "clr");
      idle();
      @(negedge clk);
      chk("clr_selerr", sel_err, 0);
      chk("clr_errcnt", err_cnt, 0);
      rd(1, 5, "badwr_b1");
      rd(2, 5, "badwr_b2");
      idle();
      drain("drain_b");

      // bad selects with enables low are ignored
      drive(0, 4'b1111, 0, '0, '0, 0, 4'b0000, 0, 0, "en_low");
      idle();
      @(negedge clk) chk("enlow_errcnt", err_cnt, 0);

      // all-zero read select dropped; r_data holds
      drive(0, '0, '0, '0, '0, 1, 4'b0000, 5, 0, "bad_rd");
      idle();
      @(negedge clk);
      chk("badrd_errcnt", err_cnt, 1);
      chk("rdata_hold", r_data, last_rd);
      drive(1, 4'b0011, 0, '0, '1, 1, 4'b1100, 0, 0, "both_bad");
      idle();
      @(negedge clk) chk("both_errcnt", err_cnt, 3);

      // saturation
      drive(0, '0, '0, '0, '0, 0, '0, '0, 1, "clr");
      for (int i = 0; i < 300; i++)
         drive(0, '0, '0, '0, '0, 1, (i % 2) ? 4'b0000 : 4'b1001, '0, 0, "sat");
      idle();
      @(negedge clk);
      chk("sat_errcnt", err_cnt, 255);
      chk("sat_selerr", sel_err, 1);
      drive(1, 4'b1100, 0, '0, '1, 1, 4'b0000, 0, 0, "sat_more");
      idle();
      @(negedge clk) chk("sat_hold", err_cnt, 255);
      drive(1, 4'b0110, 0, '0, '1, 0, '0, '0, 1, "clr_err1");
      idle();
      @(negedge clk);
      chk("clrwin_errcnt", err_cnt, 1);
      chk("clrwin_selerr", sel_err, 1);
      drive(1, 4'b0110, 0, '0, '1, 1, 4'b0000, 0, 1, "clr_err2");
      idle();
      @(negedge clk) chk("clrwin2_errcnt", err_cnt, 2);
      drive(0, '0, '0, '0, '0, 0, '0, '0, 1, "clr");
      idle();
      drain("drain_c");

      // asynchronous reset kills a pending read result
      @(posedge clk); #1;
      rd_en = 1; rd_sel = 4'b0010; r_addr = 5;
      @(posedge clk); #1;
      rd_en = 0;
      chk("pre_rst_rvalid", r_valid, 1);
      chk("pre_rst_rdata", r_data, 32'h55);
      #2 rst = 1;
      rd_en = 1; rd_sel = 4'b0100; r_addr = 5;
      #1;
      chk("async_rst_rvalid", r_valid, 0);
      chk("async_rst_rdata", r_data, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0; rd_en = 0; rd_sel = '0;
      last_rd = '0;
      pulses = 0;
      repeat (4) @(negedge clk) if (r_valid) pulses++;
      chk("post_rst_pulses", pulses, 0);

      // first request right after release is accepted
      @(posedge clk); #1 rst = 1;
      #2 rst = 0;
      apply(0, '0, '0, '0, '0, 1, 4'b0100, 5, 0, "first_after_rst");
      idle();
      drain("drain_d");

      for (int i = 0; i < 2000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); i++)
         @(posedge clk);
      chk("sweep_done", g_sw[0].done && g_sw[1].done && g_sw[2].done, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
